firm_loader: RTL and testbench

- Sits directly downstream of the SPI memory-mapped bridge.
- Consumes its 16-bit firmware halfword stream (firm_wr/firm_data/firm_ack) and its CPU start request (cpu_start/cpu_start_ack).
- Packs halfword pairs into 32-bit words and writes them to incrementing addresses in the CPU instruction RAM over a valid/ready port.
- Holds the RISC-V core in reset until the start request arrives, then releases it.

---
 rtl/firm_loader_pkg.sv | 32 +++
 rtl/firm_loader.sv | 208 ++++++++++++++++++++
 tb/tb_firm_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/firm_loader_pkg.sv
// Shared definitions for the firmware loader.
//   - state_t   : loader FSM encoding (LOW, HIGH, WRITE, RUN)
//   - HALF_W    : width of one firmware halfword from the SPI bridge
//   - WORD_W    : width of one instruction RAM word
//   - pack_half : replace the low or high halfword of a RAM word
package firm_loader_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOW   = 2'd0,
    HIGH  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Insert a halfword into the lower (upper=0) or upper (upper=1) half of a word.
  function automatic logic [WORD_W-1:0] pack_half(input logic [WORD_W-1:0] word,
                                                  input logic [HALF_W-1:0] half,
                                                  input logic              upper);
    logic [WORD_W-1:0] res;
    res = word;
    if (upper) begin
      res[WORD_W-1:HALF_W] = half;
    end else begin
      res[HALF_W-1:0] = half;
    end
    return res;
  endfunction

endpackage

// File: rtl/firm_loader.sv
// Firmware loader: packs little-endian halfword pairs from the SPI bridge into
// 32-bit words, writes them to incrementing instruction RAM addresses, and
// holds the CPU core in reset until the bridge issues a start request.
//
// Optional feature macro: FIRM_LOADER_CHECKSUM_EN
//   defined   -> checksum is the modulo-2^32 sum of every word accepted by RAM
//   undefined -> checksum is tied to zero
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   firm_wr       in   halfword request (held until acked)
//   firm_data     in   firmware halfword
//   firm_ack      out  one-cycle capture acknowledge
//   cpu_start     in   start request (held until acked)
//   cpu_start_ack out  one-cycle start acknowledge
//   mem_wr_en     out  RAM write valid
//   mem_addr      out  RAM word address
//   mem_wr_data   out  RAM write data
//   mem_wr_ready  in   RAM accepts write when high together with mem_wr_en
//   cpu_reset     out  active-high CPU core hold
//   load_count    out  words written since reset
//   load_err      out  sticky: data dropped (overflow or after start)
//   checksum      out  running sum of accepted words (feature build only)
module firm_loader
  import firm_loader_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  firm_wr,
  input  logic [HALF_W-1:0]     firm_data,
  output logic                  firm_ack,
  input  logic                  cpu_start,
  output logic                  cpu_start_ack,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_err,
  output logic [WORD_W-1:0]     checksum
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_r,     state_s;
  logic                    firm_ack_r,  firm_ack_s;
  logic                    start_ack_r, start_ack_s;
  logic                    wr_en_r,     wr_en_s;
  logic [ADDR_WIDTH-1:0]   addr_r,      addr_s;
  logic [WORD_W-1:0]       data_r,      data_s;
  logic                    cpu_rst_r,   cpu_rst_s;
  logic [ADDR_WIDTH:0]     count_r,     count_s;
  logic                    err_r,       err_s;
  logic                    capture_s;
  logic                    start_req_s;
  logic                    overflow_s;
`ifdef FIRM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]       sum_r,       sum_s;
`endif

  // A request is new only while its acknowledge is low; the bridge keeps the
  // request high during the ack cycle and that cycle must not recapture.
  assign capture_s   = firm_wr & ~firm_ack_r;
  assign start_req_s = cpu_start & ~start_ack_r;
  // RAM is full once every word address has been written exactly once.
  assign overflow_s  = count_r[ADDR_WIDTH];

  // Next-state and next-output logic of the packer / write-port FSM.
  always_comb begin
    state_s     = state_r;
    firm_ack_s  = 1'b0;
    start_ack_s = 1'b0;
    wr_en_s     = wr_en_r;
    addr_s      = addr_r;
    data_s      = data_r;
    cpu_rst_s   = cpu_rst_r;
    count_s     = count_r;
    err_s       = err_r;
`ifdef FIRM_LOADER_CHECKSUM_EN
    sum_s       = sum_r;
`endif
    case (state_r)
      LOW: begin
        // A pending halfword wins over a simultaneous start request.
        if (capture_s) begin
          data_s     = pack_half(data_r, firm_data, 1'b0);
          firm_ack_s = 1'b1;
          state_s    = HIGH;
        end else if (start_req_s) begin
          cpu_rst_s   = 1'b0;
          start_ack_s = 1'b1;
          state_s     = RUN;
        end else begin
          state_s = LOW;
        end
      end
      HIGH: begin
        if (capture_s || start_req_s) begin
          // A start with an odd halfword count flushes the partial word
          // with a zero upper half; start is then taken from LOW.
          if (capture_s) begin
            data_s     = pack_half(data_r, firm_data, 1'b1);
            firm_ack_s = 1'b1;
          end else begin
            data_s = pack_half(data_r, 16'h0000, 1'b1);
          end
          if (overflow_s) begin
            err_s   = 1'b1;
            state_s = LOW;
          end else begin
            wr_en_s = 1'b1;
            state_s = WRITE;
          end
        end else begin
          state_s = HIGH;
        end
      end
      WRITE: begin
        if (mem_wr_ready) begin
          wr_en_s = 1'b0;
          addr_s  = addr_r + ADDR_ONE;
          count_s = count_r + COUNT_ONE;
          state_s = LOW;
`ifdef FIRM_LOADER_CHECKSUM_EN
          sum_s   = sum_r + data_r;
`endif
        end else begin
          state_s = WRITE;
        end
      end
      RUN: begin
        // Late firmware is acknowledged so the bridge never stalls, but dropped.
        if (capture_s) begin
          firm_ack_s = 1'b1;
          err_s      = 1'b1;
        end else begin
          firm_ack_s = 1'b0;
        end
        if (start_req_s) begin
          start_ack_s = 1'b1;
        end else begin
          start_ack_s = 1'b0;
        end
        cpu_rst_s = 1'b0;
        state_s   = RUN;
      end
      default: begin
        wr_en_s = 1'b0;
        state_s = LOW;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= LOW;
      firm_ack_r  <= 1'b0;
      start_ack_r <= 1'b0;
      wr_en_r     <= 1'b0;
      addr_r      <= BASE_ADDR;
      data_r      <= 32'h0000_0000;
      cpu_rst_r   <= 1'b1;
      count_r     <= {(ADDR_WIDTH+1){1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      firm_ack_r  <= firm_ack_s;
      start_ack_r <= start_ack_s;
      wr_en_r     <= wr_en_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      cpu_rst_r   <= cpu_rst_s;
      count_r     <= count_s;
      err_r       <= err_s;
    end
  end

`ifdef FIRM_LOADER_CHECKSUM_EN
  // Running sum of accepted words; only changes on an accepting RAM edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r <= 32'h0000_0000;
    end else begin
      sum_r <= sum_s;
    end
  end
  assign checksum = sum_r;
`else
  assign checksum = 32'h0000_0000;
`endif

  assign firm_ack      = firm_ack_r;
  assign cpu_start_ack = start_ack_r;
  assign mem_wr_en     = wr_en_r;
  assign mem_addr      = addr_r;
  assign mem_wr_data   = data_r;
  assign cpu_reset     = cpu_rst_r;
  assign load_count    = count_r;
  assign load_err      = err_r;

endmodule

// File: tb/tb_firm_loader.sv
// Directed testbench for firm_loader. A full-size instance covers packing,
// back-pressure, start/flush, run-mode drops and asynchronous reset; a second
// instance with a 4-word RAM covers overflow. Checksum expectations follow
// FIRM_LOADER_CHECKSUM_EN.
module tb_firm_loader;

`ifdef FIRM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  // full-size instance
  logic        firm_wr, firm_ack, cpu_start, cpu_start_ack;
  logic [15:0] firm_data;
  logic        mem_wr_en, mem_wr_ready, cpu_reset, load_err;
  logic [13:0] mem_addr;
  logic [31:0] mem_wr_data, checksum;
  logic [14:0] load_count;
  // 4-word instance
  logic        firm_wr2, firm_ack2, cpu_start2, cpu_start_ack2;
  logic [15:0] firm_data2;
  logic        mem_wr_en2, mem_wr_ready2, cpu_reset2, load_err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wr_data2, checksum2;
  logic [2:0]  load_count2;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int ack_cnt2 = 0;
  logic [31:0] la_q[$], ld_q[$], la2_q[$], ld2_q[$];

  firm_loader dut (
    .clk(clk), .reset(reset), .firm_wr(firm_wr), .firm_data(firm_data),
    .firm_ack(firm_ack), .cpu_start(cpu_start), .cpu_start_ack(cpu_start_ack),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .cpu_reset(cpu_reset), .load_count(load_count),
    .load_err(load_err), .checksum(checksum)
  );

  firm_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .firm_wr(firm_wr2), .firm_data(firm_data2),
    .firm_ack(firm_ack2), .cpu_start(cpu_start2), .cpu_start_ack(cpu_start_ack2),
    .mem_wr_en(mem_wr_en2), .mem_addr(mem_addr2), .mem_wr_data(mem_wr_data2),
    .mem_wr_ready(mem_wr_ready2), .cpu_reset(cpu_reset2), .load_count(load_count2),
    .load_err(load_err2), .checksum(checksum2)
  );

  always #5 clk = ~clk;

  // Log accepted RAM writes and count acknowledge-high cycles.
  always @(negedge clk) begin
    if (mem_wr_en && mem_wr_ready) begin
      la_q.push_back({18'd0, mem_addr});
      ld_q.push_back(mem_wr_data);
    end
    if (mem_wr_en2 && mem_wr_ready2) begin
      la2_q.push_back({30'd0, mem_addr2});
      ld2_q.push_back(mem_wr_data2);
    end
    if (firm_ack)  ack_cnt  <= ack_cnt + 1;
    if (firm_ack2) ack_cnt2 <= ack_cnt2 + 1;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one halfword, wait for its ack, hold the request through the
  // ack cycle, then drop it and confirm the ack was a single cycle.
  task automatic send_half(input bit which, input logic [15:0] d, output int lat);
    logic ack_v;
    ack_v = 1'b0;
    lat = 0;
    if (which) begin firm_wr2 = 1'b1; firm_data2 = d; end
    else       begin firm_wr  = 1'b1; firm_data  = d; end
    for (int n = 1; n <= 40 && !ack_v; n++) begin
      @(posedge clk);
      @(negedge clk);
      ack_v = which ? firm_ack2 : firm_ack;
      lat = n;
    end
    chk("firm_ack_seen", 64'(ack_v), 64'(1'b1));
    step();
    if (which) firm_wr2 = 1'b0; else firm_wr = 1'b0;
    @(negedge clk);
    chk("firm_ack_one_cycle", 64'(which ? firm_ack2 : firm_ack), 64'(1'b0));
  endtask

  task automatic send_start(output logic prev_rst, output int wr_at_ack);
    logic ack_v;
    ack_v = 1'b0;
    prev_rst = cpu_reset;
    wr_at_ack = 0;
    cpu_start = 1'b1;
    for (int n = 1; n <= 40 && !ack_v; n++) begin
      @(posedge clk);
      @(negedge clk);
      ack_v = cpu_start_ack;
      if (!ack_v) prev_rst = cpu_reset;
    end
    chk("start_ack_seen", 64'(ack_v), 64'(1'b1));
    chk("cpu_reset_at_ack", 64'(cpu_reset), 64'(1'b0));
    wr_at_ack = la_q.size();
    step();
    cpu_start = 1'b0;
    @(negedge clk);
    chk("start_ack_one_cycle", 64'(cpu_start_ack), 64'(1'b0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_firm_ack"},   64'(firm_ack),      64'(1'b0));
    chk({tag, "_start_ack"},  64'(cpu_start_ack), 64'(1'b0));
    chk({tag, "_mem_wr_en"},  64'(mem_wr_en),     64'(1'b0));
    chk({tag, "_mem_addr"},   64'(mem_addr),      64'(14'd0));
    chk({tag, "_wr_data"},    64'(mem_wr_data),   64'(32'h0));
    chk({tag, "_cpu_reset"},  64'(cpu_reset),     64'(1'b1));
    chk({tag, "_load_count"}, 64'(load_count),    64'(15'd0));
    chk({tag, "_load_err"},   64'(load_err),      64'(1'b0));
    chk({tag, "_checksum"},   64'(checksum),      64'(32'h0));
  endtask

  initial begin
    int lat, base, n0, n1, wr_at_ack;
    logic prev_rst;
    logic [15:0] hw2 [10];
    reset = 1'b0;
    firm_wr = 1'b0;  firm_data = 16'h0;  cpu_start = 1'b0;  mem_wr_ready = 1'b0;
    firm_wr2 = 1'b0; firm_data2 = 16'h0; cpu_start2 = 1'b0; mem_wr_ready2 = 1'b1;
    hw2 = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234,
            16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111, 16'h2222};

    // reset state
    #12;
    chk_reset_vals("rst");
    chk("rst_dut2_cpu_reset", 64'(cpu_reset2), 64'(1'b1));
    step();
    reset = 1'b1;
    mem_wr_ready = 1'b1;

    // four halfwords, RAM always ready
    base = ack_cnt;
    send_half(1'b0, 16'h1111, lat);
    send_half(1'b0, 16'h2222, lat);
    send_half(1'b0, 16'h3333, lat);
    send_half(1'b0, 16'h4444, lat);
    repeat (2) @(negedge clk);
    chk("t1_ack_pulses", 64'(ack_cnt - base), 64'(4));
    chk("t1_writes", 64'(la_q.size()), 64'(2));
    chk("t1_addr0", 64'(la_q[0]), 64'(32'd0));
    chk("t1_data0", 64'(ld_q[0]), 64'(32'h22221111));
    chk("t1_addr1", 64'(la_q[1]), 64'(32'd1));
    chk("t1_data1", 64'(ld_q[1]), 64'(32'h44443333));
    chk("t1_load_count", 64'(load_count), 64'(15'd2));
    chk("t1_mem_addr", 64'(mem_addr), 64'(14'd2));
    chk("t1_cpu_reset", 64'(cpu_reset), 64'(1'b1));
    chk("t1_checksum", 64'(checksum), 64'(CK ? 32'h66664444 : 32'h0));

    // back-pressure: RAM not ready while 0xBEEFCAFE is pending
    step();
    mem_wr_ready = 1'b0;
    send_half(1'b0, 16'hCAFE, lat);
    send_half(1'b0, 16'hBEEF, lat);
    step();
    firm_wr = 1'b1;
    firm_data = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_wr_en_held", 64'(mem_wr_en), 64'(1'b1));
      chk("t2_addr_held", 64'(mem_addr), 64'(14'd2));
      chk("t2_data_held", 64'(mem_wr_data), 64'(32'hBEEFCAFE));
      chk("t2_no_ack", 64'(firm_ack), 64'(1'b0));
    end
    chk("t2_no_write_yet", 64'(la_q.size()), 64'(2));
    step();
    mem_wr_ready = 1'b1;
    send_half(1'b0, 16'h5555, lat);
    chk("t2_writes", 64'(la_q.size()), 64'(3));
    chk("t2_addr", 64'(la_q[2]), 64'(32'd2));
    chk("t2_data", 64'(ld_q[2]), 64'(32'hBEEFCAFE));
    chk("t2_load_count", 64'(load_count), 64'(15'd3));
    chk("t2_checksum", 64'(checksum), 64'(CK ? 32'h25560F42 : 32'h0));

    // asynchronous reset while a write is pending
    step();
    mem_wr_ready = 1'b0;
    send_half(1'b0, 16'h6666, lat);
    chk("t6_wr_en_before", 64'(mem_wr_en), 64'(1'b1));
    #2 reset = 1'b0;
    #1 chk_reset_vals("t6");
    step();
    step();
    reset = 1'b1;
    mem_wr_ready = 1'b1;

    // odd halfword count, then start: partial word flushed before the ack
    n0 = la_q.size();
    send_half(1'b0, 16'hAAAA, lat);
    send_half(1'b0, 16'hBBBB, lat);
    send_half(1'b0, 16'hCCCC, lat);
    send_start(prev_rst, wr_at_ack);
    chk("t3_writes_at_ack", 64'(wr_at_ack), 64'(n0 + 2));
    chk("t3_data0", 64'(ld_q[n0]), 64'(32'hBBBBAAAA));
    chk("t3_addr1", 64'(la_q[n0+1]), 64'(32'd1));
    chk("t3_data1", 64'(ld_q[n0+1]), 64'(32'h0000CCCC));
    chk("t3_cpu_reset_before_ack", 64'(prev_rst), 64'(1'b1));
    chk("t3_load_err", 64'(load_err), 64'(1'b0));
    chk("t3_checksum", 64'(checksum), 64'(CK ? 32'hBBBC7776 : 32'h0));

    // halfword after start: acked, dropped, error flagged
    n1 = la_q.size();
    send_half(1'b0, 16'h1234, lat);
    chk("t4_ack_latency", 64'(lat), 64'(1));
    repeat (3) @(negedge clk);
    chk("t4_no_write", 64'(la_q.size()), 64'(n1));
    chk("t4_wr_en", 64'(mem_wr_en), 64'(1'b0));
    chk("t4_load_err", 64'(load_err), 64'(1'b1));
    chk("t4_load_count", 64'(load_count), 64'(15'd2));
    chk("t4_checksum_frozen", 64'(checksum), 64'(CK ? 32'hBBBC7776 : 32'h0));
    send_start(prev_rst, wr_at_ack);
    chk("t4_restart_cpu_reset", 64'(cpu_reset), 64'(1'b0));

    // 4-word RAM: ten halfwords, fifth word must be dropped
    for (int i = 0; i < 10; i++) begin
      send_half(1'b1, hw2[i], lat);
      if (i == 1) chk("t5_checksum_w1", 64'(checksum2), 64'(CK ? 32'h1 : 32'h0));
      if (i == 3) chk("t5_checksum_wrap", 64'(checksum2), 64'(32'h0));
      if (i == 7) begin
        chk("t5_err_before_ovf", 64'(load_err2), 64'(1'b0));
        chk("t5_count_full", 64'(load_count2), 64'(3'd4));
      end
    end
    repeat (3) @(negedge clk);
    chk("t5_writes", 64'(la2_q.size()), 64'(4));
    chk("t5_addr3", 64'(la2_q[3]), 64'(32'd3));
    chk("t5_data0", 64'(ld2_q[0]), 64'(32'h00000001));
    chk("t5_data1", 64'(ld2_q[1]), 64'(32'hFFFFFFFF));
    chk("t5_data2", 64'(ld2_q[2]), 64'(32'h56781234));
    chk("t5_data3", 64'(ld2_q[3]), 64'(32'hDEF09ABC));
    chk("t5_load_err", 64'(load_err2), 64'(1'b1));
    chk("t5_load_count", 64'(load_count2), 64'(3'd4));
    chk("t5_addr_wrap", 64'(mem_addr2), 64'(2'd0));
    chk("t5_wr_en", 64'(mem_wr_en2), 64'(1'b0));
    chk("t5_acks", 64'(ack_cnt2), 64'(10));
    chk("t5_checksum", 64'(checksum2), 64'(CK ? 32'h3568ACF0 : 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
